hv_resp_parser: RTL and testbench

//  Receive-side counterpart of the HV supply command builder. Consumes the byte stream returned
//  by the HV module (UART RX byte strobe) and parses frames STX(0x02), payload, ETX(0x03),
//  2 ASCII-hex checksum chars, CR(0x0D). Checks the checksum, then presents the payload with a
//  one-cycle valid pulse. Flags checksum, format and timeout errors. Sits between UART RX and
//  the HV status/slow-control registers.

---
 rtl/hv_resp_parser.sv | 155 +++++++++++++++
 tb/tb_hv_resp_parser.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_resp_parser.sv
// Receive-side parser for HV supply responses: STX, payload, ETX, two ASCII-hex checksum
// chars, CR. Good frames update the payload registers; bad ones pulse one error flag.
module hv_resp_parser #(
  parameter int MAX_LEN     = 12,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 Clk_In,
  input  logic                 Rst_N,
  input  logic [8:1]           In_Byte,
  input  logic                 In_En,
  output logic [8*MAX_LEN:1]   Out_Payload,
  output logic [LEN_W-1:0]     Out_Len,
  output logic                 Out_Frame_Valid,
  output logic                 Out_Err_Chk,
  output logic                 Out_Err_Fmt,
  output logic                 Out_Err_Timeout,
  output logic                 Out_Busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PAYLOAD = 3'd1;
  localparam logic [2:0] S_CHK_HI  = 3'd2;
  localparam logic [2:0] S_CHK_LO  = 3'd3;
  localparam logic [2:0] S_WAIT_CR = 3'd4;

  logic [2:0]           state;
  logic [8*MAX_LEN:1]   shift_reg;
  logic [8*MAX_LEN:1]   shift_next;
  logic [LEN_W-1:0]     count;
  logic [8:1]           sum;
  logic [8:1]           rx_chk;
  logic [TMR_W-1:0]     timer;
  logic [3:0]           nib;
  logic                 nib_ok;

  // Only uppercase hex is accepted; lowercase is a format error.
  always_comb begin
    nib_ok = 1'b1;
    nib    = 4'h0;
    if (In_Byte >= 8'h30 && In_Byte <= 8'h39) begin
      nib = In_Byte[4:1];
    end else if (In_Byte >= 8'h41 && In_Byte <= 8'h46) begin
      nib = In_Byte[4:1] + 4'd9;
    end else begin
      nib_ok = 1'b0;
    end
  end

  always_comb begin
    shift_next      = shift_reg << 8;
    shift_next[8:1] = In_Byte;
  end

  assign Out_Busy = (state != S_IDLE);

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      state           <= S_IDLE;
      shift_reg       <= '0;
      count           <= '0;
      sum             <= '0;
      rx_chk          <= '0;
      timer           <= '0;
      Out_Payload     <= '0;
      Out_Len         <= '0;
      Out_Frame_Valid <= 1'b0;
      Out_Err_Chk     <= 1'b0;
      Out_Err_Fmt     <= 1'b0;
      Out_Err_Timeout <= 1'b0;
    end else begin
      Out_Frame_Valid <= 1'b0;
      Out_Err_Chk     <= 1'b0;
      Out_Err_Fmt     <= 1'b0;
      Out_Err_Timeout <= 1'b0;
      if (In_En) begin
        timer <= '0;
        case (state)
          S_IDLE: begin
            if (In_Byte == 8'h02) begin
              state     <= S_PAYLOAD;
              shift_reg <= '0;
              count     <= '0;
              sum       <= 8'h05;
            end
          end
          S_PAYLOAD: begin
            if (In_Byte == 8'h03) begin
              state <= S_CHK_HI;
            end else if (In_Byte == 8'h02) begin
              shift_reg   <= '0;
              count       <= '0;
              sum         <= 8'h05;
              Out_Err_Fmt <= 1'b1;
            end else if (count == LEN_MAX) begin
              Out_Err_Fmt <= 1'b1;
              state       <= S_IDLE;
            end else begin
              shift_reg <= shift_next;
              count     <= count + 1'b1;
              sum       <= sum + In_Byte;
            end
          end
          S_CHK_HI: begin
            if (nib_ok) begin
              rx_chk[8:5] <= nib;
              state       <= S_CHK_LO;
            end else begin
              Out_Err_Fmt <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_CHK_LO: begin
            if (nib_ok) begin
              rx_chk[4:1] <= nib;
              state       <= S_WAIT_CR;
            end else begin
              Out_Err_Fmt <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_WAIT_CR: begin
            state <= S_IDLE;
            if (In_Byte != 8'h0D) begin
              Out_Err_Fmt <= 1'b1;
            end else if (rx_chk == sum) begin
              Out_Payload     <= shift_reg;
              Out_Len         <= count;
              Out_Frame_Valid <= 1'b1;
            end else begin
              Out_Err_Chk <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // Expiry lands on the TIMEOUT_CYC-th silent cycle since the last byte.
        if (timer == TMR_LAST) begin
          Out_Err_Timeout <= 1'b1;
          state           <= S_IDLE;
          timer           <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hv_resp_parser.sv
// Scoreboard bench for hv_resp_parser: directed frames plus randomized frames, predicted by
// a frame-level reference model and checked by an independent monitor process.
module tb_hv_resp_parser;

  localparam int ML = 12;
  localparam int LW = 4;
  localparam int TO = 30;
  localparam int PW = 8 * ML;

  localparam int K_NONE    = 0;
  localparam int K_VALID   = 1;
  localparam int K_CHK     = 2;
  localparam int K_FMT     = 3;
  localparam int K_TIMEOUT = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;
    logic [PW:1] payload;
    int          len;
  } exp_t;

  logic          Clk_In = 1'b0;
  logic          Rst_N  = 1'b0;
  logic [8:1]    In_Byte = '0;
  logic          In_En   = 1'b0;
  logic [PW:1]   Out_Payload;
  logic [LW-1:0] Out_Len;
  logic          Out_Frame_Valid;
  logic          Out_Err_Chk;
  logic          Out_Err_Fmt;
  logic          Out_Err_Timeout;
  logic          Out_Busy;

  exp_t exp_q[$];
  bit   busy_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   check_en   = 1'b0;

  bit          m_in_frame;
  int          m_phase;
  logic [7:0]  m_pay[$];
  int          m_hi, m_lo, m_idle;
  logic [PW:1] m_last_pay;
  int          m_last_len;

  hv_resp_parser #(
    .MAX_LEN(ML),
    .LEN_W(LW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .Clk_In(Clk_In),
    .Rst_N(Rst_N),
    .In_Byte(In_Byte),
    .In_En(In_En),
    .Out_Payload(Out_Payload),
    .Out_Len(Out_Len),
    .Out_Frame_Valid(Out_Frame_Valid),
    .Out_Err_Chk(Out_Err_Chk),
    .Out_Err_Fmt(Out_Err_Fmt),
    .Out_Err_Timeout(Out_Err_Timeout),
    .Out_Busy(Out_Busy)
  );

  always #5 Clk_In = ~Clk_In;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int hexVal(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    return -1;
  endfunction

  function automatic logic [7:0] hexChar(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic [7:0] badHexChar(input int n);
    return (n >= 10) ? 8'(87 + n) : 8'h47;
  endfunction

  task automatic expectPulse(input int k);
    exp_t e;
    e.kind    = k;
    e.payload = m_last_pay;
    e.len     = m_last_len;
    exp_q.push_back(e);
  endtask

  task automatic modelReset();
    m_in_frame = 1'b0;
    m_phase    = 0;
    m_pay.delete();
    m_hi       = 0;
    m_lo       = 0;
    m_idle     = 0;
    m_last_pay = '0;
    m_last_len = 0;
  endtask

  // Frame-level reference: collects the payload, sums it only when the CR arrives.
  task automatic modelStep(input bit en, input logic [7:0] b);
    int hv;
    int s;
    if (!en) begin
      if (m_in_frame) begin
        m_idle++;
        if (m_idle == TO) begin
          expectPulse(K_TIMEOUT);
          m_in_frame = 1'b0;
        end
      end
    end else begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (b == 8'h02) begin
          m_in_frame = 1'b1;
          m_phase    = 0;
          m_pay.delete();
        end
      end else if (m_phase == 0) begin
        if (b == 8'h03) m_phase = 1;
        else if (b == 8'h02) begin
          m_pay.delete();
          expectPulse(K_FMT);
        end else if (m_pay.size() == ML) begin
          expectPulse(K_FMT);
          m_in_frame = 1'b0;
        end else m_pay.push_back(b);
      end else if (m_phase == 1 || m_phase == 2) begin
        hv = hexVal(b);
        if (hv < 0) begin
          expectPulse(K_FMT);
          m_in_frame = 1'b0;
        end else begin
          if (m_phase == 1) m_hi = hv;
          else m_lo = hv;
          m_phase++;
        end
      end else begin
        m_in_frame = 1'b0;
        if (b != 8'h0D) expectPulse(K_FMT);
        else begin
          s = 5;
          foreach (m_pay[i]) s += int'(m_pay[i]);
          s = s % 256;
          if (m_hi * 16 + m_lo == s) begin
            m_last_pay = '0;
            foreach (m_pay[i]) m_last_pay = (m_last_pay << 8) | PW'(m_pay[i]);
            m_last_len = m_pay.size();
            expectPulse(K_VALID);
          end else expectPulse(K_CHK);
        end
      end
    end
    busy_q.push_back(m_in_frame);
  endtask

  task automatic applyStimulus(input bit en, input logic [7:0] b);
    @(negedge Clk_In);
    In_En   = en;
    In_Byte = b;
    modelStep(en, b);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic sendSeq(input bq_t seq);
    foreach (seq[i]) applyStimulus(1'b1, seq[i]);
  endtask

  task automatic settleAfterEdge();
    @(posedge Clk_In);
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_payload"}, 128'(Out_Payload), 128'd0);
    checkOutput({tag, "_len"}, 128'(Out_Len), 128'd0);
    checkOutput({tag, "_pulses"}, 128'({Out_Frame_Valid, Out_Err_Chk, Out_Err_Fmt, Out_Err_Timeout}), 128'd0);
    checkOutput({tag, "_busy"}, 128'(Out_Busy), 128'd0);
  endtask

  task automatic resetAndRelease(input string tag);
    @(negedge Clk_In);
    Rst_N    = 1'b0;
    check_en = 1'b0;
    In_En    = 1'b0;
    In_Byte  = '0;
    modelReset();
    #2;
    checkAllZero(tag);
    @(negedge Clk_In);
    @(negedge Clk_In);
    Rst_N = 1'b1;
    modelStep(1'b0, 8'h00);
    check_en = 1'b1;
  endtask

  task automatic monitorCycle();
    int   kind;
    int   npulse;
    exp_t e;
    bit   b;
    npulse = int'(Out_Frame_Valid) + int'(Out_Err_Chk) + int'(Out_Err_Fmt) + int'(Out_Err_Timeout);
    kind = Out_Frame_Valid ? K_VALID : Out_Err_Chk ? K_CHK : Out_Err_Fmt ? K_FMT :
           Out_Err_Timeout ? K_TIMEOUT : K_NONE;
    if (busy_q.size() > 0) begin
      b = busy_q.pop_front();
      checkOutput("busy", 128'(Out_Busy), 128'(b));
    end
    if (npulse > 1) checkOutput("single_pulse", 128'(npulse), 128'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("pulse_kind", 128'(kind), 128'(e.kind));
      checkOutput("payload", 128'(Out_Payload), 128'(e.payload));
      checkOutput("len", 128'(Out_Len), 128'(e.len));
    end else if (kind != K_NONE) begin
      checkOutput("unexpected_pulse", 128'(kind), 128'(K_NONE));
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk_In);
      #1;
      if (check_en) monitorCycle();
    end
  end

  task automatic randomFrame();
    bq_t        f;
    int         len, sel, s, gapAt;
    logic [7:0] b;
    sel = int'($urandom_range(0, 15));
    len = (sel == 0) ? ML + 1 : int'($urandom_range(0, ML));
    if ($urandom_range(0, 3) == 0) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h02) b = 8'h55;
      applyStimulus(1'b1, b);
    end
    f.push_back(8'h02);
    s = 5;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h02 || b == 8'h03) b = 8'h41;
      f.push_back(b);
      s += int'(b);
    end
    if (sel == 4 && len > 0) f.insert(int'($urandom_range(1, len)), 8'h02);
    s = s % 256;
    if (sel == 1) s = (s + 1) % 256;
    f.push_back(8'h03);
    f.push_back((sel == 2) ? badHexChar(s / 16) : hexChar(s / 16));
    f.push_back(hexChar(s % 16));
    f.push_back((sel == 3) ? 8'h0A : 8'h0D);
    gapAt = int'($urandom_range(1, f.size() - 1));
    foreach (f[i]) begin
      if (i == gapAt && sel == 5) idleCycles(TO);
      else if (i == gapAt && sel == 6) idleCycles(TO - 1);
      else if ($urandom_range(0, 4) == 0) idleCycles(int'($urandom_range(1, 3)));
      applyStimulus(1'b1, f[i]);
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 600000");
    $fatal(1);
  end

  initial begin
    bq_t hon, hon_bad, ovf;
    modelReset();
    hon     = '{8'h02, 8'h48, 8'h4F, 8'h4E, 8'h03, 8'h45, 8'h41, 8'h0D};
    hon_bad = '{8'h02, 8'h48, 8'h4F, 8'h4E, 8'h03, 8'h45, 8'h42, 8'h0D};
    ovf     = '{8'h02};
    for (int i = 0; i < ML + 1; i++) ovf.push_back(8'h31);

    #2;
    checkAllZero("reset");
    @(negedge Clk_In);
    Rst_N = 1'b1;
    modelStep(1'b0, 8'h00);
    check_en = 1'b1;
    idleCycles(2);

    sendSeq(hon);
    settleAfterEdge();
    checkOutput("t1_valid", 128'(Out_Frame_Valid), 128'd1);
    checkOutput("t1_len", 128'(Out_Len), 128'd3);
    checkOutput("t1_payload", 128'(Out_Payload[24:1]), 128'h484F4E);

    sendSeq(hon_bad);
    settleAfterEdge();
    checkOutput("t2_err_chk", 128'(Out_Err_Chk), 128'd1);
    checkOutput("t2_len_hold", 128'(Out_Len), 128'd3);
    checkOutput("t2_payload_hold", 128'(Out_Payload[24:1]), 128'h484F4E);

    sendSeq(ovf);
    settleAfterEdge();
    checkOutput("t3_err_fmt", 128'(Out_Err_Fmt), 128'd1);
    checkOutput("t3_busy", 128'(Out_Busy), 128'd0);

    sendSeq('{8'h02, 8'h48, 8'h03, 8'h64});
    settleAfterEdge();
    checkOutput("t4_lower_fmt", 128'(Out_Err_Fmt), 128'd1);
    sendSeq('{8'h02, 8'h48, 8'h03, 8'h34, 8'h44, 8'h0D});
    settleAfterEdge();
    checkOutput("t4_valid", 128'(Out_Frame_Valid), 128'd1);
    checkOutput("t4_len", 128'(Out_Len), 128'd1);
    checkOutput("t4_payload", 128'(Out_Payload), 128'h48);

    sendSeq('{8'h02, 8'h48});
    idleCycles(TO);
    settleAfterEdge();
    checkOutput("t5_timeout", 128'(Out_Err_Timeout), 128'd1);
    checkOutput("t5_busy", 128'(Out_Busy), 128'd0);
    sendSeq('{8'h02, 8'h48});
    idleCycles(TO - 1);
    sendSeq('{8'h4F, 8'h4E, 8'h03, 8'h45, 8'h41, 8'h0D});
    settleAfterEdge();
    checkOutput("t5_byte_wins_valid", 128'(Out_Frame_Valid), 128'd1);
    sendSeq(hon);
    sendSeq(hon);

    sendSeq('{8'h02, 8'h48, 8'h4F});
    resetAndRelease("t6_reset");
    sendSeq(hon);
    settleAfterEdge();
    checkOutput("t6_valid", 128'(Out_Frame_Valid), 128'd1);

    for (int n = 0; n < 150; n++) begin
      randomFrame();
      if ($urandom_range(0, 1) == 0) idleCycles(int'($urandom_range(1, 4)));
    end
    idleCycles(TO + 2);

    @(negedge Clk_In);
    check_en = 1'b0;
    checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
